// File: rtl/avalon_hex_display.sv
`timescale 1ns/1ps
// Avalon-MM seven-segment display controller: 1..8 active-low digits driven from one
// value register, shown as hex or as decimal through a multi-cycle double-dabble converter.
module avalon_hex_display #(
  parameter int unsigned DIGITS        = 4,
  parameter logic [31:0] BLINK_DIV_RST = 32'd25_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            avs_address,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [31:0]           avs_writedata,
  output logic [31:0]           avs_readdata,
  output logic [7*DIGITS-1:0]   hex_out
);

  localparam int unsigned ValW      = 4 * DIGITS;
  // Two spare nibbles catch decimal results wider than the display.
  localparam int unsigned AccW      = 4 * (DIGITS + 2);
  localparam int unsigned CntW      = $clog2(ValW);
  localparam logic [CntW-1:0] ShiftLast = CntW'(ValW - 1);

  typedef enum logic [1:0] {StIdle, StShift, StCommit} conv_state_e;

  // Register file
  logic [ValW-1:0]   value_q;
  logic [2:0]        ctrl_q;
  logic [DIGITS-1:0] blank_q;
  logic [DIGITS-1:0] blink_q;
  logic [31:0]       blink_div_q;

  // Conversion datapath and displayed digits
  conv_state_e       state_q, state_d;
  logic [ValW-1:0]   shift_q, shift_d;
  logic [AccW-1:0]   bcd_q, bcd_d, bcd_adj;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ValW-1:0]   digit_q, digit_d;
  logic              overflow_q, overflow_d;
  logic [AccW+ValW-1:0] dd_next;

  // Blink timebase
  logic [31:0]       blink_cnt_q;
  logic              phase_q;

  logic [7*DIGITS-1:0] seg_d;
  logic [31:0]         rdata;
  logic                busy;
  logic [3:0]          nib;
  logic                zero_run;

  logic wr_value, wr_ctrl, wr_blank, wr_blink, wr_div;
  logic to_dec, to_hex;
  logic unused_wdata;

  assign wr_value = avs_write && (avs_address == 3'd0);
  assign wr_ctrl  = avs_write && (avs_address == 3'd1);
  assign wr_blank = avs_write && (avs_address == 3'd2);
  assign wr_blink = avs_write && (avs_address == 3'd3);
  assign wr_div   = avs_write && (avs_address == 3'd4);

  // Mode transitions only act on an actual change of the mode bit.
  assign to_dec = wr_ctrl && avs_writedata[0] && !ctrl_q[0];
  assign to_hex = wr_ctrl && !avs_writedata[0] && ctrl_q[0];

  assign busy         = (state_q != StIdle);
  assign unused_wdata = ^avs_writedata;

  // Software-visible registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q     <= '0;
      ctrl_q      <= 3'b100;
      blank_q     <= '0;
      blink_q     <= '0;
      blink_div_q <= BLINK_DIV_RST;
    end else begin
      if (wr_value) value_q     <= avs_writedata[ValW-1:0];
      if (wr_ctrl)  ctrl_q      <= avs_writedata[2:0];
      if (wr_blank) blank_q     <= avs_writedata[DIGITS-1:0];
      if (wr_blink) blink_q     <= avs_writedata[DIGITS-1:0];
      if (wr_div)   blink_div_q <= avs_writedata;
    end
  end

  // Read mux from pre-write state so a same-cycle write is not visible yet
  always_comb begin
    rdata = '0;
    case (avs_address)
      3'd0:    rdata[ValW-1:0]   = value_q;
      3'd1:    rdata[2:0]        = ctrl_q;
      3'd2:    rdata[DIGITS-1:0] = blank_q;
      3'd3:    rdata[DIGITS-1:0] = blink_q;
      3'd4:    rdata             = blink_div_q;
      3'd5:    rdata[1:0]        = {overflow_q, busy};
      default: rdata             = '0;
    endcase
  end

  // Registered read data, latency 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      avs_readdata <= rdata;
    end
  end

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(DIGITS) + 2; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  assign dd_next = {bcd_adj, shift_q} << 1;

  // Conversion FSM next state, plus hex loads and aborts that override it
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    digit_d    = digit_q;
    overflow_d = overflow_q;

    unique case (state_q)
      StIdle: ;
      StShift: begin
        bcd_d   = dd_next[AccW+ValW-1:ValW];
        shift_d = dd_next[ValW-1:0];
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == ShiftLast) state_d = StCommit;
      end
      StCommit: begin
        digit_d    = bcd_q[ValW-1:0];
        overflow_d = |bcd_q[AccW-1:ValW];
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (to_hex) begin
      state_d    = StIdle;
      digit_d    = value_q;
      overflow_d = 1'b0;
    end else if (wr_value) begin
      if (ctrl_q[0]) begin
        // Restart from the new value; the displayed digits wait for COMMIT.
        state_d = StShift;
        shift_d = avs_writedata[ValW-1:0];
        bcd_d   = '0;
        cnt_d   = '0;
      end else begin
        digit_d    = avs_writedata[ValW-1:0];
        overflow_d = 1'b0;
      end
    end else if (to_dec) begin
      state_d = StShift;
      shift_d = value_q;
      bcd_d   = '0;
      cnt_d   = '0;
    end
  end

  // Conversion FSM and digit registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      digit_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      digit_q    <= digit_d;
      overflow_q <= overflow_d;
    end
  end

  // Blink timebase: phase flips each time the counter wraps; divider 0 freezes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (wr_div || (blink_div_q == 32'd0)) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (blink_cnt_q >= blink_div_q - 32'd1) begin
      blink_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 32'd1;
    end
  end

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Per-digit segment selection; scan from the top so zero_run marks leading zeros
  always_comb begin
    seg_d    = '1;
    nib      = '0;
    zero_run = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      nib      = digit_q[4*i +: 4];
      zero_run = zero_run && (nib == 4'd0);
      if (!ctrl_q[2] || blank_q[i]) begin
        seg_d[7*i +: 7] = 7'h7F;
      end else if (blink_q[i] && phase_q) begin
        seg_d[7*i +: 7] = 7'h7F;
      end else if (overflow_q && ctrl_q[0]) begin
        seg_d[7*i +: 7] = 7'h3F;
      end else if (ctrl_q[1] && (i != 0) && zero_run) begin
        seg_d[7*i +: 7] = 7'h7F;
      end else begin
        seg_d[7*i +: 7] = seg_decode(nib);
      end
    end
  end

  // Registered segment outputs, blank during reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex_out <= '1;
    end else begin
      hex_out <= seg_d;
    end
  end

endmodule

// File: tb/tb_avalon_hex_display.sv
`timescale 1ns/1ps
// Directed bench for avalon_hex_display with four digits.
module tb_avalon_hex_display;

  localparam int unsigned Digits = 4;

  localparam logic [6:0] SegBlank = 7'h7F;
  localparam logic [6:0] SegDash  = 7'h3F;
  localparam logic [6:0] Seg0 = 7'h40, Seg1 = 7'h79, Seg2 = 7'h24, Seg3 = 7'h30;
  localparam logic [6:0] Seg4 = 7'h19, Seg5 = 7'h12, Seg7 = 7'h78;
  localparam logic [6:0] Seg8 = 7'h00, Seg9 = 7'h10, SegA = 7'h08, SegF = 7'h0E;

  logic        clk;
  logic        reset;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic [27:0] hex_out;

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;
  logic        watch_nines  = 1'b0;
  int unsigned nines_seen   = 0;
  logic [31:0] rd;

  avalon_hex_display #(
    .DIGITS(Digits)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .hex_out       (hex_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [27:0] hx(input logic [6:0] d3, input logic [6:0] d2,
                                     input logic [6:0] d1, input logic [6:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  // Flags any cycle where the abandoned 9999 conversion would be on display
  always @(negedge clk) begin
    if (watch_nines && (hex_out == hx(Seg9, Seg9, Seg9, Seg9))) nines_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
    @(negedge clk);
    avs_address   = addr;
    avs_writedata = data;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
    @(negedge clk);
    avs_address = addr;
    avs_read    = 1'b1;
    @(negedge clk);
    avs_read    = 1'b0;
    data        = avs_readdata;
  endtask

  task automatic read_check(input string tag, input logic [2:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(addr, d);
    check(tag, d, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Decimal VALUE write at edge N: busy sampled at N+2 and N+16, old digits still shown
  // after N+17 (COMMIT edge), new digits after N+18, status sampled at N+20.
  task automatic dec_write_timed(input string tag, input logic [31:0] val,
                                 input logic [27:0] old_hex, input logic [27:0] new_hex,
                                 input logic [31:0] exp_status);
    logic [31:0] d;
    bus_write(3'd0, val);
    bus_read(3'd5, d);
    check({tag, "_busy_early"}, d, 32'h1);
    wait_cycles(12);
    bus_read(3'd5, d);
    check({tag, "_busy_late"}, d, 32'h1);
    @(negedge clk);
    check({tag, "_hex_before"}, {4'h0, hex_out}, {4'h0, old_hex});
    @(negedge clk);
    check({tag, "_hex_after"}, {4'h0, hex_out}, {4'h0, new_hex});
    bus_read(3'd5, d);
    check({tag, "_status_done"}, d, exp_status);
  endtask

  initial begin
    reset         = 1'b1;
    avs_address   = '0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;

    // Reset state
    @(negedge clk);
    check("rst_hex", {4'h0, hex_out}, 32'h0FFFFFFF);
    check("rst_rdata", avs_readdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_hex", {4'h0, hex_out}, {4'h0, hx(Seg0, Seg0, Seg0, Seg0)});
    read_check("ctrl_rst", 3'd1, 32'h4);
    read_check("div_rst", 3'd4, 32'd25_000_000);
    read_check("value_rst", 3'd0, 32'h0);
    read_check("addr7", 3'd7, 32'h0);

    // Hex mode: one-cycle display latency
    bus_write(3'd0, 32'h12AF);
    check("hex_lat_old", {4'h0, hex_out}, {4'h0, hx(Seg0, Seg0, Seg0, Seg0)});
    @(negedge clk);
    check("hex_12af", {4'h0, hex_out}, {4'h0, hx(Seg1, Seg2, SegA, SegF)});
    read_check("hex_status", 3'd5, 32'h0);

    // Decimal mode
    bus_write(3'd1, 32'h5);
    dec_write_timed("dec1234", 32'd1234, hx(Seg1, Seg2, SegA, SegF),
                    hx(Seg1, Seg2, Seg3, Seg4), 32'h0);

    bus_write(3'd0, 32'hFFFF);
    wait_cycles(20);
    check("dec_ovf_hex", {4'h0, hex_out}, {4'h0, hx(SegDash, SegDash, SegDash, SegDash)});
    read_check("dec_ovf_status", 3'd5, 32'h2);

    // Leading-zero suppression
    bus_write(3'd1, 32'h7);
    bus_write(3'd0, 32'd7);
    wait_cycles(20);
    check("lz_7", {4'h0, hex_out}, {4'h0, hx(SegBlank, SegBlank, SegBlank, Seg7)});
    read_check("lz_status", 3'd5, 32'h0);
    bus_write(3'd0, 32'd0);
    wait_cycles(20);
    check("lz_0", {4'h0, hex_out}, {4'h0, hx(SegBlank, SegBlank, SegBlank, Seg0)});
    bus_write(3'd0, 32'd105);
    wait_cycles(20);
    check("lz_105", {4'h0, hex_out}, {4'h0, hx(SegBlank, Seg1, Seg0, Seg5)});

    // Restart: last write wins, 9999 never shown
    bus_write(3'd1, 32'h5);
    @(negedge clk);
    check("nolz_105", {4'h0, hex_out}, {4'h0, hx(Seg0, Seg1, Seg0, Seg5)});
    watch_nines = 1'b1;
    bus_write(3'd0, 32'd9999);
    wait_cycles(4);
    dec_write_timed("restart42", 32'd42, hx(Seg0, Seg1, Seg0, Seg5),
                    hx(Seg0, Seg0, Seg4, Seg2), 32'h0);
    wait_cycles(4);
    watch_nines = 1'b0;
    check("restart_no_9999", nines_seen, 32'd0);

    // Back to hex mode reloads from VALUE (42 = 0x2A)
    bus_write(3'd1, 32'h4);
    @(negedge clk);
    check("to_hex_reload", {4'h0, hex_out}, {4'h0, hx(Seg0, Seg0, Seg2, SegA)});

    // Blanking and enable
    bus_write(3'd2, 32'h2);
    @(negedge clk);
    check("blank_d1", {4'h0, hex_out}, {4'h0, hx(Seg0, Seg0, SegBlank, SegA)});
    bus_write(3'd2, 32'h0);
    bus_write(3'd1, 32'h0);
    @(negedge clk);
    check("disable", {4'h0, hex_out}, {4'h0, hx(SegBlank, SegBlank, SegBlank, SegBlank)});
    bus_write(3'd1, 32'h4);

    // Blink digit 0 with a half-period of 4 cycles
    bus_write(3'd3, 32'h1);
    bus_write(3'd4, 32'd4);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("blink_k%0d", k), {4'h0, hex_out},
            {4'h0, hx(Seg0, Seg0, Seg2, ((((k - 1) / 4) % 2) == 1) ? SegBlank : SegA)});
    end
    bus_write(3'd4, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("blink_frozen_k%0d", k), {4'h0, hex_out},
            {4'h0, hx(Seg0, Seg0, Seg2, SegA)});
    end

    // Same-cycle read and write returns the old value
    @(negedge clk);
    avs_address   = 3'd0;
    avs_writedata = 32'h5555;
    avs_read      = 1'b1;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    check("rw_same_old", avs_readdata, 32'h2A);
    read_check("rw_same_new", 3'd0, 32'h5555);
    check("hex_5555", {4'h0, hex_out}, {4'h0, hx(Seg5, Seg5, Seg5, Seg5)});

    // Reset in the middle of a conversion
    bus_write(3'd1, 32'h5);
    bus_write(3'd0, 32'd1234);
    wait_cycles(3);
    reset = 1'b1;
    #1;
    check("midrst_hex", {4'h0, hex_out}, 32'h0FFFFFFF);
    check("midrst_rdata", avs_readdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_post_hex", {4'h0, hex_out}, {4'h0, hx(Seg0, Seg0, Seg0, Seg0)});
    read_check("midrst_ctrl", 3'd1, 32'h4);
    read_check("midrst_status", 3'd5, 32'h0);
    read_check("midrst_blink", 3'd3, 32'h0);
    wait_cycles(20);
    check("midrst_no_commit", {4'h0, hex_out}, {4'h0, hx(Seg0, Seg0, Seg0, Seg0)});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
